// File: rtl/med_pkg.sv
// med_pkg: shared FSM state type and window-length legality check for the rank filter
package med_pkg;
  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;
  localparam int NUM_MIN = 3;
  localparam int NUM_MAX = 31;
  function automatic bit num_ok(input int n);
    return n >= NUM_MIN && n <= NUM_MAX && n % 2 == 1;
  endfunction
endpackage

// File: rtl/med_cx.sv
// med_cx: unsigned compare-exchange, lower value to lo; equal values pass straight through
module med_cx #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  assign lo = (b < a) ? b : a;
  assign hi = (b < a) ? a : b;
endmodule

// File: rtl/med_rank_stream.sv
// med_rank_stream: collects NUM samples, sorts them by odd-even transposition, outputs the selected rank
module med_rank_stream
  import med_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NUM   = 9,
  localparam int RW    = $clog2(NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] di,
  input  logic             di_valid,
  output logic             di_ready,
  input  logic             byp,
  input  logic [RW-1:0]    rank,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);
  if (!num_ok(NUM)) begin : g_bad_num
    $error("med_rank_stream: NUM must be odd and within 3..31");
  end
  logic [WIDTH-1:0] r  [NUM];
  logic [WIDTH-1:0] ev [NUM];
  logic [WIDTH-1:0] od [NUM];
  state_t state, nxt;
  logic [RW-1:0] cnt, p, rank_l, sel;
  logic byp_l, in_xfer, out_xfer, last, done;
  assign in_xfer  = di_valid && state == LOAD;
  assign out_xfer = dout_ready && state == OUT;
  assign last     = in_xfer && cnt == RW'(NUM - 1);
  // p == NUM marks the extra cycle that moves the chosen element into dout; bypass jumps straight there
  assign done     = state == SORT && p == RW'(NUM);
  assign sel      = byp_l ? RW'(NUM / 2) : rank_l;
  for (genvar i = 0; i < NUM / 2; i++) begin : g_cx
    med_cx #(.WIDTH(WIDTH)) u_even (.a(r[2*i]),   .b(r[2*i+1]), .lo(ev[2*i]),   .hi(ev[2*i+1]));
    med_cx #(.WIDTH(WIDTH)) u_odd  (.a(r[2*i+1]), .b(r[2*i+2]), .lo(od[2*i+1]), .hi(od[2*i+2]));
  end
  assign ev[NUM-1] = r[NUM-1];
  assign od[0]     = r[0];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOAD;
    else state <= nxt;
  // next state and handshake outputs; clr wins over any transfer
  always_comb begin
    nxt        = state;
    di_ready   = state == LOAD;
    dout_valid = state == OUT;
    busy       = state != LOAD;
    if (clr) nxt = LOAD;
    else if (last) nxt = SORT;
    else if (done) nxt = OUT;
    else if (out_xfer) nxt = LOAD;
  end
  // window counters, latched mode/rank, and the registered result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      p      <= '0;
      byp_l  <= 1'b0;
      rank_l <= '0;
      dout   <= '0;
    end else if (clr) begin
      cnt <= '0;
      p   <= '0;
    end else begin
      if (in_xfer) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (cnt == '0) begin
          byp_l  <= byp;
          rank_l <= (int'(rank) >= NUM) ? RW'(NUM - 1) : rank;
        end
        if (last) p <= byp_l ? RW'(NUM) : '0;
      end
      if (state == SORT) p <= done ? '0 : p + 1'b1;
      if (done) dout <= r[sel];
    end
  // sample storage: filled in LOAD, one transposition pass per SORT cycle
  always_ff @(posedge clk)
    if (in_xfer) r[cnt] <= di;
    else if (state == SORT && !done)
      for (int i = 0; i < NUM; i++) r[i] <= p[0] ? od[i] : ev[i];
endmodule

// File: tb/tb_med_rank_stream.sv
// tb_med_rank_stream: table vectors, corner sequences and random windows against a sort-based model
module tb_med_rank_stream;
  logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0, di_valid = 1'b0, byp = 1'b0, dout_ready = 1'b0;
  logic [7:0] di = '0;
  logic [3:0] rank = '0;
  logic [7:0] dout;
  logic       di_ready, dout_valid, busy;
  int total = 0, bad = 0;

  typedef struct packed {
    logic [71:0] v;
    logic        byp;
    logic [3:0]  rank;
    logic [7:0]  ex;
    logic [7:0]  lat;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  med_rank_stream #(.WIDTH(8), .NUM(9)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .di(di), .di_valid(di_valid), .di_ready(di_ready),
    .byp(byp), .rank(rank), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [71:0] v, input logic b, input logic [3:0] rk);
    logic [7:0] q[$];
    for (int i = 0; i < 9; i++) q.push_back(v[71-8*i -: 8]);
    if (b) return q[4];
    q.sort();
    return q[rk > 8 ? 8 : rk];
  endfunction

  task automatic send(input logic [7:0] x, input int gap);
    di_valid = 1'b0;
    repeat (gap) @(negedge clk);
    di = x;
    di_valid = 1'b1;
    for (int n = 0; !di_ready && n < 50; n++) @(negedge clk);
    if (!di_ready) chk("di_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    di_valid = 1'b0;
  endtask

  task automatic send_win(input logic [71:0] v, input logic b, input logic [3:0] rk, input int gmax);
    byp = b;
    rank = rk;
    for (int i = 0; i < 9; i++) begin
      send(v[71-8*i -: 8], i == 0 ? 0 : int'($urandom_range(gmax, 0)));
      byp = 1'($urandom_range(1, 0));
      rank = 4'($urandom_range(15, 0));
    end
  endtask

  task automatic recv(input string name, input int exp, input int elat, input int hold);
    int cyc = 0;
    logic [7:0] d0;
    dout_ready = 1'b0;
    while (!dout_valid && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk({name, "_lat"}, cyc, elat);
    chk({name, "_dout"}, int'(dout), exp);
    d0 = dout;
    repeat (hold) begin
      @(negedge clk);
      chk({name, "_hold_dout"}, int'(dout), int'(d0));
      chk({name, "_hold_valid"}, int'(dout_valid), 1);
      chk({name, "_hold_di_ready"}, int'(di_ready), 0);
    end
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dout_ready = 1'b0;
    chk({name, "_post_valid"}, int'(dout_valid), 0);
    chk({name, "_post_di_ready"}, int'(di_ready), 1);
  endtask

  initial begin
    logic [71:0] v;
    logic b;
    logic [3:0] rk;
    tbl[0] = '{v: {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, byp: 1'b0, rank: 4'd4, ex: 8'd5, lat: 8'd10};
    tbl[1] = '{v: {8'd200, 8'd0, 8'd255, {6{8'd7}}}, byp: 1'b0, rank: 4'd0, ex: 8'd0, lat: 8'd10};
    tbl[2] = '{v: {8'd200, 8'd0, 8'd255, {6{8'd7}}}, byp: 1'b0, rank: 4'd8, ex: 8'd255, lat: 8'd10};
    tbl[3] = '{v: {8'd200, 8'd0, 8'd255, {6{8'd7}}}, byp: 1'b0, rank: 4'd12, ex: 8'd255, lat: 8'd10};
    tbl[4] = '{v: {8'd200, 8'd0, 8'd255, {6{8'd7}}}, byp: 1'b0, rank: 4'd2, ex: 8'd7, lat: 8'd10};
    tbl[5] = '{v: {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90}, byp: 1'b1, rank: 4'd0, ex: 8'd50, lat: 8'd1};
    tbl[6] = '{v: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, byp: 1'b1, rank: 4'd8, ex: 8'd5, lat: 8'd1};
    tbl[7] = '{v: {8'd5, 8'd5, 8'd5, 8'd3, 8'd3, 8'd3, 8'd9, 8'd9, 8'd9}, byp: 1'b0, rank: 4'd3, ex: 8'd5, lat: 8'd10};

    repeat (2) @(negedge clk);
    chk("reset_di_ready", int'(di_ready), 1);
    chk("reset_dout_valid", int'(dout_valid), 0);
    chk("reset_dout", int'(dout), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send_win(tbl[i].v, tbl[i].byp, tbl[i].rank, 0);
      recv($sformatf("vec%0d", i), int'(tbl[i].ex), int'(tbl[i].lat), 0);
    end

    send_win({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 1'b0, 4'd4, 0);
    recv("backpressure", 5, 10, 5);

    send_win({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 4'd4, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_dout", int'(dout), 0);
    chk("abort_dout_valid", int'(dout_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_di_ready", int'(di_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_win({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 1'b0, 4'd4, 0);
    recv("abort_next", 5, 10, 0);

    byp = 1'b1;
    rank = 4'd0;
    for (int i = 0; i < 3; i++) send(8'd0, 0);
    di = 8'd0;
    di_valid = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    di_valid = 1'b0;
    chk("clr_busy", int'(busy), 0);
    chk("clr_di_ready", int'(di_ready), 1);
    send_win({9{8'd42}}, 1'b0, 4'd4, 0);
    recv("clr_window", 42, 10, 0);

    send_win({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 4'd4, 0);
    repeat (12) @(negedge clk);
    chk("clr_out_valid_before", int'(dout_valid), 1);
    clr = 1'b1;
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    dout_ready = 1'b0;
    chk("clr_out_valid_after", int'(dout_valid), 0);
    chk("clr_out_di_ready", int'(di_ready), 1);
    send_win({8'd4, 8'd1, 8'd9, 8'd2, 8'd8, 8'd3, 8'd7, 8'd5, 8'd6}, 1'b0, 4'd7, 1);
    recv("clr_out_next", 8, 10, 0);

    for (int k = 0; k < 40; k++) begin
      v = {$urandom, $urandom, $urandom};
      if (k % 5 == 0) v[71:64] = v[63:56];
      b = ($urandom_range(3, 0) == 0);
      rk = 4'($urandom_range(15, 0));
      send_win(v, b, rk, 2);
      recv($sformatf("rand%0d", k), int'(model(v, b, rk)), b ? 1 : 10, int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
